// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook timer controller.
package cook_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_SEC10 = 4'd5;
  localparam bcd_t MAX_MIN10 = 4'd5;

  // Two-digit BCD increment that wraps from {max_tens,9} back to 00.
  function automatic logic [7:0] bcd_inc_wrap(input bcd_t tens, input bcd_t ones,
                                               input bcd_t max_tens);
    logic [7:0] r;
    if (ones == 4'd9) begin
      if (tens >= max_tens) r = 8'h00;
      else                  r = {tens + 4'd1, 4'd0};
    end else begin
      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// Loadable 4-digit BCD mm:ss down counter; holds at 00:00.
module bcd_mmss_down
  import cook_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_p,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic [15:0] count,
  output logic        zero
);

  bcd_t m10, m1, s10, s1;
  logic [15:0] count_dec;

  assign zero = (count == 16'h0000);

  // Next value one second lower, borrowing across digits and the minute.
  always_comb begin
    m10 = count[15:12];
    m1  = count[11:8];
    s10 = count[7:4];
    s1  = count[3:0];
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = MAX_SEC10;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    count_dec = {m10, m1, s10, s1};
  end

  // Counter register: load wins over decrement, no decrement past zero.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)            count <= 16'h0000;
    else if (load)          count <= load_val;
    else if (dec && !zero)  count <= count_dec;
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Kitchen cook timer controller: set mm:ss, count down, alarm with auto-silence.
// Optional feature macro: COOK_TIMER_PAUSE_EN (start toggles RUN <-> PAUSE).
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int unsigned ALARM_TIMEOUT_S = 60
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        btn_start,
  input  logic        btn_inc_sec,
  input  logic        btn_inc_min,
  input  logic        btn_alarm_off,
  input  logic        tick_1s,
  output logic [15:0] value,
  output logic        running,
  output logic        alarm,
  output logic        alarm_led
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ALARM_TIMEOUT_S - 1);

  state_t      state, state_nxt;
  logic [7:0]  set_min, set_sec;
  logic [7:0]  to_cnt, to_cnt_nxt;
  logic        led_nxt;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic [15:0] cnt_value;
  logic        inc_sec, inc_min;
  logic        win_off, win_start, win_min, win_sec;
  logic        set_nonzero;

  assign win_off     = btn_alarm_off;
  assign win_start   = btn_start & ~btn_alarm_off;
  assign win_min     = btn_inc_min & ~btn_start & ~btn_alarm_off;
  assign win_sec     = btn_inc_sec & ~btn_inc_min & ~btn_start & ~btn_alarm_off;
  assign set_nonzero = |{set_min, set_sec};

  bcd_mmss_down u_counter (
    .clk      (clk),
    .reset_p  (reset_p),
    .load     (cnt_load),
    .load_val ({set_min, set_sec}),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  // Next-state, counter control, alarm timeout and LED toggle decisions.
  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    inc_sec    = 1'b0;
    inc_min    = 1'b0;
    to_cnt_nxt = 8'd0;
    led_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_start) begin
          if (set_nonzero) begin
            cnt_load  = 1'b1;
            state_nxt = S_RUN;
          end
        end else begin
          inc_min = win_min;
          inc_sec = win_sec;
        end
      end
      S_RUN: begin
        if (win_start) begin
`ifdef COOK_TIMER_PAUSE_EN
          state_nxt = S_PAUSE;
`else
          state_nxt = S_IDLE;
`endif
        end else if (cnt_zero) begin
          state_nxt = S_ALARM;
        end else if (tick_1s) begin
          cnt_dec = 1'b1;
        end
      end
`ifdef COOK_TIMER_PAUSE_EN
      S_PAUSE: begin
        if (win_start) state_nxt = S_RUN;
      end
`endif
      S_ALARM: begin
        to_cnt_nxt = to_cnt;
        led_nxt    = alarm_led;
        if (win_off || win_start) begin
          state_nxt  = S_IDLE;
          to_cnt_nxt = 8'd0;
        end else if (tick_1s) begin
          led_nxt = ~alarm_led;
          if (to_cnt == TIMEOUT_LAST) begin
            state_nxt  = S_IDLE;
            to_cnt_nxt = 8'd0;
          end else begin
            to_cnt_nxt = to_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, set time, alarm timeout and LED registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state     <= S_IDLE;
      set_min   <= 8'h00;
      set_sec   <= 8'h00;
      to_cnt    <= 8'd0;
      alarm_led <= 1'b0;
    end else begin
      state     <= state_nxt;
      to_cnt    <= to_cnt_nxt;
      alarm_led <= led_nxt;
      if (inc_min) set_min <= bcd_inc_wrap(set_min[7:4], set_min[3:0], MAX_MIN10);
      if (inc_sec) set_sec <= bcd_inc_wrap(set_sec[7:4], set_sec[3:0], MAX_SEC10);
    end
  end

  // Registered display and status outputs derived from the current state.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      value   <= 16'h0000;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      running <= (state == S_RUN);
      alarm   <= (state == S_ALARM);
      case (state)
        S_IDLE:  value <= {set_min, set_sec};
        S_RUN:   value <= cnt_value;
`ifdef COOK_TIMER_PAUSE_EN
        S_PAUSE: value <= cnt_value;
`endif
        default: value <= 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed self-checking bench for cook_timer_ctrl (honours COOK_TIMER_PAUSE_EN).
module tb_cook_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_inc_sec = 1'b0;
  logic        btn_inc_min = 1'b0;
  logic        btn_alarm_off = 1'b0;
  logic        tick_1s = 1'b0;
  logic [15:0] value;
  logic        running, alarm, alarm_led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cook_timer_ctrl #(.ALARM_TIMEOUT_S(60)) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .btn_start     (btn_start),
    .btn_inc_sec   (btn_inc_sec),
    .btn_inc_min   (btn_inc_min),
    .btn_alarm_off (btn_alarm_off),
    .tick_1s       (tick_1s),
    .value         (value),
    .running       (running),
    .alarm         (alarm),
    .alarm_led     (alarm_led)
  );

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the given pulses for exactly one rising edge; starts and ends at a negedge.
  task automatic press(input logic s, input logic m, input logic i, input logic o, input logic t);
    btn_start = s; btn_inc_min = m; btn_inc_sec = i; btn_alarm_off = o; tick_1s = t;
    @(negedge clk);
    btn_start = 0; btn_inc_min = 0; btn_inc_sec = 0; btn_alarm_off = 0; tick_1s = 0;
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    wait_cycles(2);
    reset_p = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    wait_cycles(2);
    checks++;
    if ({value, running, alarm, alarm_led} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h/%b%b%b expected 0000/000", value, running, alarm, alarm_led);
    end
    reset_p = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_countdown();
    do_reset();
    repeat (3) press(0, 1, 0, 0, 0);
    repeat (2) press(0, 0, 1, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0302) begin errors++; $display("[TB] FAIL countdown_set: got %h expected 0302", value); end
    press(1, 0, 0, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0302 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL countdown_start: got %h run=%b expected 0302 run=1", value, running);
    end
    for (int i = 1; i <= 182; i++) begin
      press(0, 0, 0, 0, 1);
      wait_cycles(1);
      checks++;
      if (value !== to_bcd(182 - i) || running !== 1'b1 || alarm !== 1'b0) begin
        errors++;
        $display("[TB] FAIL countdown_step%0d: got %h run=%b alarm=%b expected %h run=1 alarm=0",
                 i, value, running, alarm, to_bcd(182 - i));
      end
    end
    wait_cycles(1);
    checks++;
    if (alarm !== 1'b1 || running !== 1'b0 || value !== 16'h0000 || alarm_led !== 1'b0) begin
      errors++;
      $display("[TB] FAIL countdown_alarm: got alarm=%b run=%b value=%h led=%b expected 1 0 0000 0",
               alarm, running, value, alarm_led);
    end
    press(0, 0, 0, 1, 0);
    wait_cycles(1);
    checks++;
    if (alarm !== 1'b0 || value !== 16'h0302) begin
      errors++; $display("[TB] FAIL countdown_ack: got alarm=%b value=%h expected 0 0302", alarm, value);
    end
  endtask

  task automatic test_inc_wrap();
    do_reset();
    repeat (10) press(0, 0, 1, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0010) begin errors++; $display("[TB] FAIL sec_carry: got %h expected 0010", value); end
    repeat (49) press(0, 0, 1, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0059) begin errors++; $display("[TB] FAIL sec_59: got %h expected 0059", value); end
    press(0, 0, 1, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0000) begin errors++; $display("[TB] FAIL sec_wrap: got %h expected 0000", value); end
    press(1, 0, 0, 0, 0);
    wait_cycles(2);
    checks++;
    if (running !== 1'b0 || value !== 16'h0000) begin
      errors++; $display("[TB] FAIL start_zero: got run=%b value=%h expected 0 0000", running, value);
    end
    repeat (59) press(0, 1, 0, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h5900) begin errors++; $display("[TB] FAIL min_59: got %h expected 5900", value); end
    press(0, 1, 0, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0000) begin errors++; $display("[TB] FAIL min_wrap: got %h expected 0000", value); end
  endtask

  task automatic test_borrow();
    do_reset();
    press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0059 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL borrow: got %h run=%b expected 0059 run=1", value, running);
    end
  endtask

  task automatic test_priority();
    do_reset();
    press(0, 1, 1, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0100) begin errors++; $display("[TB] FAIL prio_min_over_sec: got %h expected 0100", value); end
    press(0, 1, 0, 1, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0100) begin errors++; $display("[TB] FAIL prio_off_over_min: got %h expected 0100", value); end
    press(1, 1, 0, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0100 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL prio_start_over_min: got %h run=%b expected 0100 run=1", value, running);
    end
  endtask

  task automatic test_start_tick();
    do_reset();
    repeat (10) press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0010 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL st_run: got %h run=%b expected 0010 run=1", value, running);
    end
    press(1, 0, 0, 0, 1);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0010 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL st_same_cycle: got %h run=%b expected 0010 run=0", value, running);
    end
    press(0, 0, 1, 0, 0);
    wait_cycles(1);
`ifdef COOK_TIMER_PAUSE_EN
    checks++;
    if (value !== 16'h0010) begin errors++; $display("[TB] FAIL st_pause_inc: got %h expected 0010", value); end
    press(0, 0, 0, 0, 1);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0010) begin errors++; $display("[TB] FAIL st_pause_tick: got %h expected 0010", value); end
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0009 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL st_resume: got %h run=%b expected 0009 run=1", value, running);
    end
`else
    checks++;
    if (value !== 16'h0011) begin errors++; $display("[TB] FAIL st_idle_inc: got %h expected 0011", value); end
`endif
  endtask

  task automatic test_alarm_timeout();
    do_reset();
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    wait_cycles(2);
    checks++;
    if (alarm !== 1'b1 || alarm_led !== 1'b0 || value !== 16'h0000) begin
      errors++; $display("[TB] FAIL to_enter: got alarm=%b led=%b value=%h expected 1 0 0000", alarm, alarm_led, value);
    end
    for (int k = 1; k <= 60; k++) begin
      press(0, 0, 0, 0, 1);
      checks++;
      if (alarm !== 1'b1 || alarm_led !== 1'(k % 2)) begin
        errors++; $display("[TB] FAIL to_tick%0d: got alarm=%b led=%b expected 1 %0d", k, alarm, alarm_led, k % 2);
      end
      wait_cycles(1);
    end
    checks++;
    if (alarm !== 1'b0 || alarm_led !== 1'b0 || running !== 1'b0 || value !== 16'h0001) begin
      errors++; $display("[TB] FAIL to_expire: got alarm=%b led=%b run=%b value=%h expected 0 0 0 0001",
                         alarm, alarm_led, running, value);
    end
  endtask

  task automatic test_alarm_ack();
    do_reset();
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    wait_cycles(2);
    press(1, 0, 0, 0, 0);
    wait_cycles(1);
    checks++;
    if (alarm !== 1'b0 || value !== 16'h0001) begin
      errors++; $display("[TB] FAIL ack_start: got alarm=%b value=%h expected 0 0001", alarm, value);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    press(0, 1, 0, 0, 0);
    repeat (45) press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    wait_cycles(1);
    checks++;
    if (value !== 16'h0145 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_pre: got %h run=%b expected 0145 run=1", value, running);
    end
    #2 reset_p = 1'b1;
    #1;
    checks++;
    if ({value, running, alarm, alarm_led} !== 19'd0) begin
      errors++; $display("[TB] FAIL rst_async: got %h/%b%b%b expected 0000/000", value, running, alarm, alarm_led);
    end
    btn_inc_min = 1'b1; btn_start = 1'b1;
    @(negedge clk);
    btn_inc_min = 1'b0; btn_start = 1'b0;
    reset_p = 1'b0;
    wait_cycles(1);
    checks++;
    if (value !== 16'h0000 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_settime: got %h run=%b expected 0000 run=0", value, running);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_inc_wrap();
    test_borrow();
    test_priority();
    test_start_tick();
    test_alarm_timeout();
    test_alarm_ack();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cook_timer_ctrl.md
COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 SHALL have parameter ALARM_TIMEOUT_S, default 60, meaning alarm auto-silence time in 1 s ticks (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port reset_p  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port btn_start  input  1  one-cycle start/stop pulse from the debounced edge detector.
REQ-005 SHALL have port btn_inc_sec  input  1  one-cycle pulse that increments the set seconds.
REQ-006 SHALL have port btn_inc_min  input  1  one-cycle pulse that increments the set minutes.
REQ-007 SHALL have port btn_alarm_off  input  1  one-cycle alarm acknowledge pulse.
REQ-008 SHALL have port tick_1s  input  1  one-cycle pulse every second from the prescaler chain.
REQ-009 SHALL have port value  output  16  BCD {min10,min1,sec10,sec1} for the 4-digit FND driver.
REQ-010 SHALL have port running  output  1  high in RUN.
REQ-011 SHALL have port alarm  output  1  high in ALARM.
REQ-012 SHALL have port alarm_led  output  1  alarm LED; toggles on each tick_1s in ALARM, 0 elsewhere.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, ALARM.
REQ-014 SHALL, in IDLE only, apply btn_inc_sec as set seconds +1 BCD: x9 -> (x+1)0, 59 -> 00, no carry into minutes.
REQ-015 SHALL, in IDLE only, apply btn_inc_min as set minutes +1 BCD with 59 -> 00 wrap.
REQ-016 SHALL ignore inc pulses in RUN, PAUSE and ALARM.
REQ-017 SHALL treat btn_start in IDLE with set time 00:00 as a no-op.
REQ-018 SHALL, on btn_start in IDLE with non-zero set time, load the current counter from the set time and enter RUN on the next edge; set time is retained.
REQ-019 SHALL decrement the current counter by one second per tick_1s in RUN: sec 00 -> 59 with a minute borrow; digit x0 -> (x-1)9.
REQ-020 SHALL, when a tick brings the counter to 00:00, enter ALARM on the following edge, with no further decrement.
REQ-021 SHALL, on btn_start and tick_1s in the same RUN cycle, give priority to btn_start and perform no decrement.
REQ-022 SHALL, in ALARM, return to IDLE on btn_alarm_off or btn_start, or after ALARM_TIMEOUT_S ticks.
REQ-023 SHALL, when several button pulses arrive in one cycle, resolve priority as alarm_off > start > inc_min > inc_sec, acting only on the winner.
REQ-024 SHALL drive value with the set time in IDLE, the current counter in RUN/PAUSE, and 16'h0000 in ALARM.
REQ-025 SHALL register all outputs, valid one cycle after the state or counter change.

Reset
REQ-026 SHALL, on reset_p asserted at any time including mid-RUN or mid-ALARM, force state IDLE, set time 00:00, current counter 00:00, alarm timeout counter 0, value 0, running 0, alarm 0, alarm_led 0.
REQ-027 SHALL ignore all inputs while reset_p is high.

Configuration
REQ-028 SHALL, with COOK_TIMER_PAUSE_EN defined, move RUN to PAUSE on btn_start (counter held, tick ignored) and PAUSE back to RUN on btn_start, with no reload.
REQ-029 SHALL, without COOK_TIMER_PAUSE_EN, move RUN to IDLE on btn_start (abort, counter discarded); the PAUSE state is then unreachable and no PAUSE logic is synthesized.

Structure
REQ-030 SHALL place the state enum, a 4-bit BCD digit typedef and the constants MAX_SEC10=5 and MAX_MIN10=5 in the shared package cook_timer_pkg.
REQ-031 SHALL instantiate one sub-module, bcd_mmss_down: a loadable 4-digit BCD mm:ss down counter with load, dec and zero outputs.

Verification
REQ-032 SHALL verify: 3x inc_min, 2x inc_sec, start, 182 ticks -> value counts 0302 to 0000, alarm=1 one cycle after the edge following the 0000 tick.
REQ-033 SHALL verify: 60x inc_sec from 00 -> set seconds wrap to 00, minutes remain 00; then start -> state stays IDLE, running=0.
REQ-034 SHALL verify: set 01:00, start, one tick -> value 0059 (borrow across the minute).
REQ-035 SHALL verify: RUN at 0010 with start and tick in the same cycle -> value stays 0010; PAUSE with the macro, IDLE without it.
REQ-036 SHALL verify: ALARM with no acknowledge -> alarm=0 and IDLE after exactly 60 ticks, alarm_led toggling each tick.
REQ-037 SHALL verify: reset_p pulsed mid-RUN at 0145 -> every output is 0 immediately (asynchronous), set time 0000.
